// File: rtl/serial_compare_ctrl.sv
// serial_compare_ctrl: sequencer that feeds two parallel operands
// MSB-first into a bit-serial magnitude comparator and latches its verdict.
module serial_compare_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             ready,
  output logic             busy,
  output logic             valid,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic             cmp_reset,
  output logic             cmp_a,
  output logic             cmp_b,
  input  logic             cmp_g,
  input  logic             cmp_e,
  input  logic             cmp_l
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CW-1:0]    cnt;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state; abort wins over every INIT/SHIFT transition.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = INIT;
      INIT:    state_nx = abort ? IDLE : SHIFT;
      SHIFT: begin
        if (abort)            state_nx = IDLE;
        else if (cnt == LAST) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand shift registers and bit counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sa  <= '0;
      sb  <= '0;
      cnt <= '0;
    end else if (state == IDLE && start) begin
      sa  <= op_a;
      sb  <= op_b;
      cnt <= '0;
    end else if (state == SHIFT) begin
      sa  <= {sa[WIDTH-2:0], 1'b0};
      sb  <= {sb[WIDTH-2:0], 1'b0};
      cnt <= cnt + 1'b1;
    end
  end

  // Verdict capture with a single-cycle valid pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      gt    <= 1'b0;
      eq    <= 1'b0;
      lt    <= 1'b0;
    end else begin
      valid <= (state == DONE);
      if (state == DONE) begin
        gt <= cmp_g;
        eq <= cmp_e;
        lt <= cmp_l;
      end
    end
  end

  assign ready     = (state == IDLE);
  assign busy      = (state != IDLE);
  assign cmp_reset = reset | (state == INIT);
  assign cmp_a     = (state == SHIFT) & sa[WIDTH-1];
  assign cmp_b     = (state == SHIFT) & sb[WIDTH-1];

endmodule
